crc32_stream: RTL and testbench

CRC32_STREAM -- requirements
Module: crc32_stream

---
 rtl/crc32_pkg.sv | 27 ++
 rtl/crc32_comb.sv | 23 ++
 rtl/crc32_stream.sv | 155 +++++++++++++++
 tb/tb_crc32_stream.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// crc32_pkg: shared constants, FSM state type and the single-byte update
// function for the IEEE 802.3 CRC-32 stream engine (reflected, LSB first).
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TAIL = 2'd1,
    ST_DONE = 2'd2
  } crc32_state_t;

  // One byte folded into the register, bit 0 of the byte first.
  function automatic logic [31:0] crc32_step_byte(input logic [31:0] crc,
                                                  input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_comb.sv
// crc32_comb: combinational CRC-32 update over BYTES bytes in one step.
// Ports:
//   i_crc  - running CRC register in (pre-inversion)
//   i_data - BYTES bytes, byte 0 in bits [7:0] and folded first
//   o_crc  - updated CRC register
module crc32_comb
  import crc32_pkg::*;
#(
  parameter int BYTES = 8
) (
  input  logic [31:0]        i_crc,
  input  logic [8*BYTES-1:0] i_data,
  output logic [31:0]        o_crc
);

  always_comb begin
    o_crc = i_crc;
    for (int unsigned k = 0; k < BYTES; k++) begin
      o_crc = crc32_step_byte(o_crc, i_data[8*k +: 8]);
    end
  end

endmodule

// File: rtl/crc32_stream.sv
// crc32_stream: streaming IEEE 802.3 CRC-32 over BYTES-wide beats.
// Full beats fold in one cycle; a partial last beat is folded one byte per
// cycle in TAIL. The result is presented for one cycle in DONE, which can
// also accept the first beat of the next frame.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   s_valid/ready  - beat handshake
//   s_data         - beat data, byte k = s_data[8k+7:8k], byte 0 first
//   s_last         - final beat of frame
//   s_nbytes       - valid bytes in last beat (0 = all BYTES)
//   s_abort        - discard the frame in progress (highest priority)
//   crc_out        - final CRC of most recent frame, held between pulses
//   crc_valid      - one-cycle pulse when crc_out updates
//   crc_ok         - FCS residue check (only with CRC32_STREAM_CHECK_EN)
// Optional feature macro: CRC32_STREAM_CHECK_EN
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int BYTES = 8,
  parameter int NB_W  = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*BYTES-1:0] s_data,
  input  logic               s_last,
  input  logic [NB_W-1:0]    s_nbytes,
  input  logic               s_abort,
  output logic [31:0]        crc_out,
  output logic               crc_valid
`ifdef CRC32_STREAM_CHECK_EN
  ,
  output logic               crc_ok
`endif
);

  crc32_state_t       r_state, w_state_nxt;
  logic [31:0]        r_crc, w_crc_nxt;
  logic [8*BYTES-1:0] r_tail_data, w_tail_data_nxt;
  logic [NB_W-1:0]    r_tail_cnt, w_tail_cnt_nxt;
  logic [31:0]        r_crc_out, w_crc_out_nxt;
  logic               r_crc_valid, w_crc_valid_nxt;

  logic [31:0]        w_beat_crc;
  logic [31:0]        w_byte_crc;
  logic [31:0]        w_final;
  logic               w_finish;
  logic               w_accept;
  logic               w_partial;

  crc32_comb #(.BYTES(BYTES)) u_comb (
    .i_crc  (r_crc),
    .i_data (s_data),
    .o_crc  (w_beat_crc)
  );

  assign w_byte_crc = crc32_step_byte(r_crc, r_tail_data[7:0]);
  assign s_ready    = (r_state != ST_TAIL);
  assign w_accept   = s_valid && s_ready;
  assign w_partial  = (BYTES > 1) && s_last && (s_nbytes != '0);
  assign crc_out    = r_crc_out;
  assign crc_valid  = r_crc_valid;

  // The running CRC already reloads INIT on entry to DONE, so a beat taken
  // in DONE needs no separate seed mux.
  always_comb begin
    w_state_nxt     = r_state;
    w_crc_nxt       = r_crc;
    w_tail_data_nxt = r_tail_data;
    w_tail_cnt_nxt  = r_tail_cnt;
    w_crc_out_nxt   = r_crc_out;
    w_crc_valid_nxt = 1'b0;
    w_finish        = 1'b0;
    w_final         = w_beat_crc;
    if (s_abort) begin
      w_state_nxt    = ST_RUN;
      w_crc_nxt      = CRC32_INIT;
      w_tail_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_RUN, ST_DONE: begin
          w_state_nxt = ST_RUN;
          if (w_accept) begin
            if (w_partial) begin
              w_state_nxt     = ST_TAIL;
              w_tail_data_nxt = s_data;
              w_tail_cnt_nxt  = s_nbytes;
            end else if (s_last) begin
              w_finish = 1'b1;
              w_final  = w_beat_crc;
            end else begin
              w_crc_nxt = w_beat_crc;
            end
          end
        end
        ST_TAIL: begin
          w_crc_nxt       = w_byte_crc;
          w_tail_data_nxt = r_tail_data >> 8;
          w_tail_cnt_nxt  = r_tail_cnt - NB_W'(1);
          if (r_tail_cnt == NB_W'(1)) begin
            w_finish = 1'b1;
            w_final  = w_byte_crc;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
      if (w_finish) begin
        w_state_nxt     = ST_DONE;
        w_crc_nxt       = CRC32_INIT;
        w_crc_out_nxt   = w_final ^ CRC32_XOROUT;
        w_crc_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc       <= CRC32_INIT;
      r_tail_data <= '0;
      r_tail_cnt  <= '0;
      r_crc_out   <= '0;
      r_crc_valid <= 1'b0;
    end else begin
      r_crc       <= w_crc_nxt;
      r_tail_data <= w_tail_data_nxt;
      r_tail_cnt  <= w_tail_cnt_nxt;
      r_crc_out   <= w_crc_out_nxt;
      r_crc_valid <= w_crc_valid_nxt;
    end
  end

`ifdef CRC32_STREAM_CHECK_EN
  logic r_crc_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc_ok <= 1'b0;
    end else if (w_finish) begin
      r_crc_ok <= (w_final == CRC32_RESIDUE);
    end
  end

  assign crc_ok = r_crc_ok;
`endif

endmodule

// File: tb/tb_crc32_stream.sv
module tb_crc32_stream;

  typedef byte unsigned bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_valid, s_ready, s_last, s_abort, crc_valid;
  logic [63:0] s_data;
  logic [2:0]  s_nbytes;
  logic [31:0] crc_out;
  logic        b_valid, b_ready, b_last, b_abort, b_crc_valid;
  logic [7:0]  b_data;
  logic [0:0]  b_nbytes;
  logic [31:0] b_crc_out;
`ifdef CRC32_STREAM_CHECK_EN
  logic        crc_ok, b_crc_ok;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  crc32_stream #(.BYTES(8), .NB_W(3)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .s_nbytes(s_nbytes),
    .s_abort(s_abort), .crc_out(crc_out), .crc_valid(crc_valid)
`ifdef CRC32_STREAM_CHECK_EN
    , .crc_ok(crc_ok)
`endif
  );

  crc32_stream #(.BYTES(1), .NB_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready),
    .s_data(b_data), .s_last(b_last), .s_nbytes(b_nbytes),
    .s_abort(b_abort), .crc_out(b_crc_out), .crc_valid(b_crc_valid)
`ifdef CRC32_STREAM_CHECK_EN
    , .crc_ok(b_crc_ok)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Textbook bitwise CRC-32 over a whole message.
  function automatic logic [31:0] ref_crc(input bq_t m);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (m[i]) begin
      c = c ^ {24'h0, m[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t rand_msg(input int len);
    bq_t m;
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  function automatic bq_t str_msg(input string s);
    bq_t m;
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    return m;
  endfunction

  // Beat b of message m; bytes past the end are random to show they are ignored.
  function automatic logic [63:0] pack(input bq_t m, input int b);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) begin
      d[8*k +: 8] = (8*b + k < m.size()) ? m[8*b + k] : 8'($urandom);
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input bq_t m);
    int nb;
    nb = (m.size() + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      s_valid  = 1'b1;
      s_data   = pack(m, b);
      s_last   = (b == nb - 1);
      s_nbytes = (b == nb - 1) ? 3'(m.size() % 8) : 3'($urandom);
      chk("beat_ready", 32'(s_ready), 32'd1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called one cycle after the last beat was taken.
  task automatic expect_result(input bq_t m, input logic [31:0] exp, input string tag);
    int n;
    n = m.size() % 8;
    for (int c = 0; c < n; c++) begin
      chk({tag, "_tail_ready"}, 32'(s_ready), 32'd0);
      chk({tag, "_tail_novalid"}, 32'(crc_valid), 32'd0);
      tick();
    end
    chk({tag, "_valid"}, 32'(crc_valid), 32'd1);
    chk({tag, "_crc"}, crc_out, exp);
    tick();
    chk({tag, "_pulse"}, 32'(crc_valid), 32'd0);
    chk({tag, "_hold"}, crc_out, exp);
  endtask

  task automatic quiet(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      chk({tag, "_novalid"}, 32'(crc_valid), 32'd0);
      tick();
    end
  endtask

  // Byte-wide instance: one byte per cycle, result expected right after the last byte.
  task automatic send_bytes(input bq_t m, input logic [31:0] exp, input string tag);
    for (int i = 0; i < m.size(); i++) begin
      b_valid = 1'b1;
      b_data  = m[i];
      b_last  = (i == m.size() - 1);
      chk({tag, "_ready"}, 32'(b_ready), 32'd1);
      tick();
    end
    b_valid = 1'b0;
    b_last  = 1'b0;
    chk({tag, "_valid"}, 32'(b_crc_valid), 32'd1);
    chk({tag, "_crc"}, b_crc_out, exp);
  endtask

  initial begin : main
    bq_t m, ma, mb, mc;
    int  lens[6] = '{1, 8, 3, 17, 24, 40};

    rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_nbytes = '0; s_abort = 1'b0; s_data = '0;
    b_valid = 1'b0; b_last = 1'b0; b_nbytes = '0; b_abort = 1'b0; b_data = '0;
    #3;
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_crc_out", crc_out, 32'd0);
    chk("rst_valid", 32'(crc_valid), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    chk("rst_b_crc_out", b_crc_out, 32'd0);
`ifdef CRC32_STREAM_CHECK_EN
    chk("rst_ok", 32'(crc_ok), 32'd0);
`endif
    #9;
    rst = 1'b0;
    tick();

    // Known answer: two beats, partial last with one byte.
    m = str_msg("123456789");
    send_beats(m);
    expect_result(m, 32'hCBF4_3926, "kat9");

    // Directed lengths (one-beat frames, full/partial last) then random ones.
    foreach (lens[i]) begin
      m = rand_msg(lens[i]);
      send_beats(m);
      expect_result(m, ref_crc(m), "len");
    end
    for (int f = 0; f < 8; f++) begin
      m = rand_msg($urandom_range(1, 48));
      send_beats(m);
      expect_result(m, ref_crc(m), "rnd");
    end

    // Abort mid-frame, abort beat carries s_last and must be dropped.
    m = rand_msg(16);
    for (int b = 0; b < 2; b++) begin
      s_valid = 1'b1; s_data = pack(m, b); s_last = 1'b0;
      tick();
    end
    s_valid = 1'b1; s_data = 64'($urandom); s_last = 1'b1; s_nbytes = '0; s_abort = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0; s_abort = 1'b0;
    chk("abort_ready", 32'(s_ready), 32'd1);
    quiet(4, "abort");
    m = str_msg("123456789");
    send_beats(m);
    expect_result(m, 32'hCBF4_3926, "post_abort");

    // Abort while folding a partial last beat.
    m = rand_msg(13);
    send_beats(m);
    tick();
    s_abort = 1'b1;
    tick();
    s_abort = 1'b0;
    chk("tail_abort_ready", 32'(s_ready), 32'd1);
    quiet(8, "tail_abort");
    m = rand_msg(19);
    send_beats(m);
    expect_result(m, ref_crc(m), "post_tail_abort");

    // Asynchronous reset while in TAIL.
    m = rand_msg(15);
    send_beats(m);
    tick();
    rst = 1'b1;
    #2;
    chk("tail_rst_ready", 32'(s_ready), 32'd1);
    chk("tail_rst_crc_out", crc_out, 32'd0);
    chk("tail_rst_valid", 32'(crc_valid), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    quiet(8, "tail_rst");
    m = rand_msg(21);
    send_beats(m);
    expect_result(m, ref_crc(m), "post_rst");

    // Back-to-back: next frame's beats taken in DONE, full then partial.
    ma = rand_msg(16); mb = rand_msg(8); mc = rand_msg(5);
    s_valid = 1'b1; s_data = pack(ma, 0); s_last = 1'b0;
    tick();
    s_data = pack(ma, 1); s_last = 1'b1; s_nbytes = '0;
    tick();
    chk("b2b_a_valid", 32'(crc_valid), 32'd1);
    chk("b2b_a_crc", crc_out, ref_crc(ma));
    chk("b2b_done_ready", 32'(s_ready), 32'd1);
    s_data = pack(mb, 0); s_last = 1'b1; s_nbytes = '0;
    tick();
    chk("b2b_b_valid", 32'(crc_valid), 32'd1);
    chk("b2b_b_crc", crc_out, ref_crc(mb));
    s_data = pack(mc, 0); s_last = 1'b1; s_nbytes = 3'd5;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    expect_result(mc, ref_crc(mc), "b2b_c");

    // Byte-wide instance: single zero byte, known answer, back-to-back frames.
    m = '{8'h00};
    send_bytes(m, 32'hD202_EF8D, "b1_zero");
    m = str_msg("123456789");
    send_bytes(m, 32'hCBF4_3926, "b1_kat");
    m = rand_msg(7);
    send_bytes(m, ref_crc(m), "b1_rnd_a");
    m = rand_msg(11);
    send_bytes(m, ref_crc(m), "b1_rnd_b");
    tick();
    chk("b1_pulse", 32'(b_crc_valid), 32'd0);

`ifdef CRC32_STREAM_CHECK_EN
    begin : fcs_check
      logic [31:0] fcs;
      m = rand_msg(60);
      fcs = ref_crc(m);
      for (int k = 0; k < 4; k++) m.push_back(fcs[8*k +: 8]);
      send_beats(m);
      expect_result(m, ref_crc(m), "fcs_good");
      chk("fcs_good_ok", 32'(crc_ok), 32'd1);
      m[10] = m[10] ^ 8'h01;
      send_beats(m);
      expect_result(m, ref_crc(m), "fcs_bad");
      chk("fcs_bad_ok", 32'(crc_ok), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
